// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store responder for a word-wide synchronous SRAM.
// Optional MEM_ACCESS_ALIGN_CHECK_EN flags misaligned word accesses as errors.
module mem_access_unit #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [1:0]    we,
   input  logic [1:0]    ltype,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          ready,
   output logic          err,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [31:0]   mem_rdata,
   output logic [2:0]    stateshow
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RDW     = 3'd2,
      WR      = 3'd3,
      RMW_RD  = 3'd4,
      RMW_RDW = 3'd5,
      RMW_WR  = 3'd6,
      ACK     = 3'd7
   } state_t;

   state_t      state;
   logic [1:0]  lane;
   logic [1:0]  ltype_q;
   logic [7:0]  wbyte;
   logic [7:0]  lane_byte;
   logic [31:0] merged;
   logic [31:0] load_val;
   logic        misal;
   logic        unused_addr;

   assign stateshow   = state;
   assign unused_addr = ^addr[31:AW+2];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign misal = (addr[1:0] != 2'b00) &&
                  ((we == 2'b01) ||
                   ((we == 2'b00) &&
                    ((ltype == 2'b00) || (ltype == 2'b11))));
`else
   assign misal = 1'b0;
`endif

   // lane extraction for loads and byte merge for read-modify-write
   always_comb begin
      merged = mem_rdata;
      merged[{lane, 3'b000} +: 8] = wbyte;
      lane_byte = mem_rdata[{lane, 3'b000} +: 8];
      unique case (ltype_q)
         2'b01:   load_val = {24'b0, lane_byte};
         2'b10:   load_val = {{24{lane_byte[7]}}, lane_byte};
         default: load_val = mem_rdata;
      endcase
   end

   // access sequencer; strobes and ready are single-cycle registered pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ready     <= 1'b0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         rdata     <= '0;
         mem_wdata <= '0;
         mem_addr  <= '0;
         lane      <= '0;
         ltype_q   <= '0;
         wbyte     <= '0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         ready  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  mem_addr <= addr[AW+1:2];
                  lane     <= addr[1:0];
                  ltype_q  <= ltype;
                  wbyte    <= wdata[7:0];
                  if (misal) begin
                     state <= ACK;
                     ready <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     unique case (we)
                        2'b01: begin
                           state     <= WR;
                           mem_we    <= 1'b1;
                           mem_wdata <= wdata;
                        end
                        2'b10: begin
                           state  <= RMW_RD;
                           mem_re <= 1'b1;
                        end
                        2'b00: begin
                           state  <= RD;
                           mem_re <= 1'b1;
                        end
                        default: begin
                           state <= ACK;
                           ready <= 1'b1;
                           err   <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            RD: state <= RDW;
            RDW: begin
               rdata <= load_val;
               state <= ACK;
               ready <= 1'b1;
            end
            WR: begin
               state <= ACK;
               ready <= 1'b1;
            end
            RMW_RD: state <= RMW_RDW;
            RMW_RDW: begin
               mem_wdata <= merged;
               mem_we    <= 1'b1;
               state     <= RMW_WR;
            end
            RMW_WR: begin
               state <= ACK;
               ready <= 1'b1;
            end
            ACK: begin
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, reset-abort sequence and random
// accesses against an array-based reference of the byte-addressed memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  we = 2'b00;
   logic [1:0]  ltype = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata = '0;
   logic [2:0]  stateshow;

   int vectors = 0;
   int miscompares = 0;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic [31:0] sram [64];
   logic [31:0] ref_mem [64];
   logic [31:0] last_rdata = '0;

   mem_access_unit #(.AW(6)) dut (
      .clk(clk), .reset(rst_n), .req(req), .we(we), .ltype(ltype),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
      .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .stateshow(stateshow)
   );

   always #5 clk = ~clk;

   // behavioural SRAM with one cycle of read latency
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
   end

   // strobes must never overlap
   always @(negedge clk) begin
      if (mem_we && mem_re) begin
         miscompares++;
         $display("FAIL strobe_overlap: mem_we=1 and mem_re=1 together");
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // reference: memory as an array of words, bytes addressed by shifting
   task automatic model_op(input logic [1:0] w, input logic [1:0] lt,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r, output logic e,
                           output int lat, output int nwe, output int nre);
      int idx;
      int k;
      logic [31:0] b;
      idx = int'(a[7:2]);
      k = int'(a[1:0]);
      e = 1'b0; nwe = 0; nre = 0;
      if (w == 2'b11 || (ALIGN && k != 0 &&
          (w == 2'b01 || (w == 2'b00 && (lt == 2'b00 || lt == 2'b11))))) begin
         e = 1'b1; lat = 1;
      end else if (w == 2'b01) begin
         ref_mem[idx] = d; lat = 2; nwe = 1;
      end else if (w == 2'b10) begin
         ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * k))) |
                        ({24'b0, d[7:0]} << (8 * k));
         lat = 4; nwe = 1; nre = 1;
      end else begin
         b = (ref_mem[idx] >> (8 * k)) & 32'hFF;
         if (lt == 2'b01) last_rdata = b;
         else if (lt == 2'b10) last_rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
         else last_rdata = ref_mem[idx];
         lat = 3; nre = 1;
      end
      r = last_rdata;
   endtask

   task automatic run_op(input logic [1:0] w, input logic [1:0] lt,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r, output logic e,
                         output int lat, output int nwe, output int nre,
                         output logic [5:0] waddr);
      @(negedge clk);
      req = 1'b1; we = w; ltype = lt; addr = a; wdata = d;
      lat = 0; nwe = 0; nre = 0; r = '0; e = 1'b0; waddr = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_we) begin nwe++; waddr = mem_addr; end
         if (mem_re) nre++;
         if (ready) begin
            lat = c; r = rdata; e = err;
            break;
         end
      end
      req = 1'b0; we = 2'b00;
      @(negedge clk);
      chk("ready_pulse", {31'b0, ready}, 32'd0);
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [1:0]  lt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nwe;
      int          nre;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] r, mr;
      logic e, me;
      int lat, nwe, nre, mlat, mnwe, mnre, we_cnt;
      logic [5:0] waddr;
      logic [1:0] rw, rlt;
      logic [31:0] ra, rd;

      for (int i = 0; i < 64; i++) begin
         sram[i] = '0;
         ref_mem[i] = '0;
      end

      tbl[0]  = '{2'b01, 2'b00, 32'h8,  32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0};
      tbl[1]  = '{2'b00, 2'b00, 32'h8,  32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 1};
      tbl[2]  = '{2'b01, 2'b00, 32'h10, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 2, 1, 0};
      tbl[3]  = '{2'b00, 2'b10, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0, 1};
      tbl[4]  = '{2'b00, 2'b01, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 0, 1};
      tbl[5]  = '{2'b00, 2'b10, 32'h10, 32'h0, 32'h00000001, 1'b0, 3, 0, 1};
      tbl[6]  = '{2'b10, 2'b00, 32'h11, 32'hAA, 32'h00000001, 1'b0, 4, 1, 1};
      tbl[7]  = '{2'b00, 2'b00, 32'h10, 32'h0, 32'h80FFAA01, 1'b0, 3, 0, 1};
      tbl[8]  = '{2'b11, 2'b00, 32'h10, 32'h0, 32'h80FFAA01, 1'b1, 1, 0, 0};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      tbl[9]  = '{2'b00, 2'b00, 32'h9,  32'h0, 32'h80FFAA01, 1'b1, 1, 0, 0};
`else
      tbl[9]  = '{2'b00, 2'b00, 32'h9,  32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 1};
`endif
      tbl[10] = '{2'b00, 2'b10, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0, 1};
      tbl[11] = '{2'b00, 2'b11, 32'h10, 32'h0, 32'h80FFAA01, 1'b0, 3, 0, 1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_state", {29'b0, stateshow}, 32'd0);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_we_re", {30'b0, mem_we, mem_re}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_maddr", {26'b0, mem_addr}, 32'd0);
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].we, tbl[i].lt, tbl[i].addr, tbl[i].wdata,
                r, e, lat, nwe, nre, waddr);
         model_op(tbl[i].we, tbl[i].lt, tbl[i].addr, tbl[i].wdata,
                  mr, me, mlat, mnwe, mnre);
         chk($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
         chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].err});
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("tbl%0d_nwe", i), nwe, tbl[i].nwe);
         chk($sformatf("tbl%0d_nre", i), nre, tbl[i].nre);
         if (tbl[i].nwe != 0)
            chk($sformatf("tbl%0d_waddr", i), {26'b0, waddr},
                {26'b0, tbl[i].addr[7:2]});
      end

      // reset while the byte store is in RMW_RDW
      we_cnt = 0;
      @(negedge clk);
      req = 1'b1; we = 2'b10; ltype = 2'b00; addr = 32'h11; wdata = 32'h55;
      @(negedge clk);
      if (mem_we) we_cnt++;
      @(negedge clk);
      if (mem_we) we_cnt++;
      chk("abort_in_rmw_rdw", {29'b0, stateshow}, 32'd5);
      rst_n = 1'b0;
      req = 1'b0; we = 2'b00;
      #1;
      chk("abort_state", {29'b0, stateshow}, 32'd0);
      chk("abort_outs", {29'b0, ready, err, mem_we},
          32'd0);
      chk("abort_re", {31'b0, mem_re}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_wdata", mem_wdata, 32'd0);
      chk("abort_maddr", {26'b0, mem_addr}, 32'd0);
      last_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (mem_we) we_cnt++;
      end
      chk("abort_no_we", we_cnt, 0);
      chk("abort_stateshow", {29'b0, stateshow}, 32'd0);
      chk("abort_sram", sram[4], ref_mem[4]);

      // randomized accesses against the reference
      for (int i = 0; i < 150; i++) begin
         rw = 2'($urandom_range(0, 3));
         rlt = 2'($urandom_range(0, 3));
         ra = $urandom;
         if (i < 40) ra[7:2] = 6'($urandom_range(0, 3));
         rd = $urandom;
         run_op(rw, rlt, ra, rd, r, e, lat, nwe, nre, waddr);
         model_op(rw, rlt, ra, rd, mr, me, mlat, mnwe, mnre);
         chk($sformatf("rnd%0d_rdata", i), r, mr);
         chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, me});
         chk($sformatf("rnd%0d_lat", i), lat, mlat);
         chk($sformatf("rnd%0d_nwe", i), nwe, mnwe);
         chk($sformatf("rnd%0d_nre", i), nre, mnre);
      end

      for (int i = 0; i < 64; i++)
         chk($sformatf("final_mem%0d", i), sram[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
